mem_stage_rv32: RTL

MEM_STAGE_RV32 -- requirements
Module: mem_stage_rv32

---
 rtl/rv32_mem_pkg.sv | 23 ++
 rtl/mem_stage_rv32_if.sv | 21 ++
 rtl/mem_stage_rv32_align.sv | 70 +++++++
 rtl/mem_stage_rv32.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared constants for the RV32 memory stage: access-size one-hot codes,
// FSM state encoding and error codes reported on oERR.
package rv32_mem_pkg;

  // One-hot access size as delivered by the decoder on iDecodedOP
  localparam logic [4:0] SZ_B  = 5'b00001;
  localparam logic [4:0] SZ_H  = 5'b00010;
  localparam logic [4:0] SZ_W  = 5'b00100;
  localparam logic [4:0] SZ_BU = 5'b01000;
  localparam logic [4:0] SZ_HU = 5'b10000;

  // Two-state transaction FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Error pulse codes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_stage_rv32_if.sv
// Data-bus bundle between the memory stage (master) and the memory/bus
// fabric (slave). Signal prefixes are from the memory stage's point of view.
interface mem_stage_rv32_if;
  logic        oBUS_REQ;
  logic        oBUS_WE;
  logic [31:0] oBUS_ADDR;
  logic [3:0]  oBUS_BE;
  logic [31:0] oBUS_WDATA;
  logic        iBUS_ACK;
  logic [31:0] iBUS_RDATA;

  modport master (
    output oBUS_REQ, oBUS_WE, oBUS_ADDR, oBUS_BE, oBUS_WDATA,
    input  iBUS_ACK, iBUS_RDATA
  );

  modport slave (
    input  oBUS_REQ, oBUS_WE, oBUS_ADDR, oBUS_BE, oBUS_WDATA,
    output iBUS_ACK, iBUS_RDATA
  );
endinterface

// File: rtl/mem_stage_rv32_align.sv
// Combinational load/store alignment: byte enables, write-lane replication,
// legality/misalignment check on the request side, and lane extraction with
// sign/zero extension on the load-return side (using the captured request).
module lsu_align_rv32
  import rv32_mem_pkg::*;
(
  input  logic [4:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_err,
  input  logic [4:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic        w_is_b;
  logic        w_is_h;
  logic        w_is_w;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_is_b = (i_size == SZ_B) || (i_size == SZ_BU);
  assign w_is_h = (i_size == SZ_H) || (i_size == SZ_HU);
  assign w_is_w = (i_size == SZ_W);

  // Byte enables shifted into the addressed lane(s)
  always_comb begin
    o_be = 4'b0000;
    if (w_is_b)      o_be = 4'b0001 << i_addr_lo;
    else if (w_is_h) o_be = 4'b0011 << i_addr_lo;
    else if (w_is_w) o_be = 4'b1111;
  end

  // Non-one-hot size, unsigned size on a store, or a misaligned H/W address
  assign o_err = !$onehot(i_size)
               || (i_store && ((i_size == SZ_BU) || (i_size == SZ_HU)))
               || (w_is_h && i_addr_lo[0])
               || (w_is_w && (i_addr_lo != 2'b00));

  // Each write lane carries its own byte of a word, the matching byte of the
  // replicated halfword, or the replicated low byte
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_wdata[gi*8 +: 8] = w_is_w ? i_wdata[gi*8 +: 8]
                                : w_is_h ? i_wdata[(gi%2)*8 +: 8]
                                :          i_wdata[7:0];
    end
  endgenerate

  assign w_byte = i_rdata[{i_ld_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_ld_addr_lo[1], 4'b0000} +: 16];

  // Extract the addressed lane and extend to 32 bits
  always_comb begin
    o_ldata = i_rdata;
    case (i_ld_size)
      SZ_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_ldata = {24'd0, w_byte};
      SZ_H:    o_ldata = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_ldata = {16'd0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_rv32.sv
// RV32 memory stage: forwards ALU results, issues one data-bus transaction at
// a time for loads/stores, stalls upstream while the bus is busy, and aborts
// transactions that exceed TIMEOUT busy cycles without an ack.
module mem_stage_rv32
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
)(
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iMEM,
  input  logic             iRW,
  input  logic [31:0]      iMEMADDR,
  input  logic [31:0]      iMEMDATA,
  input  logic [31:0]      iDregDATA,
  input  logic [4:0]       iDregADDR,
  input  logic [4:0]       iDecodedOP,
  output logic             oSTALL,
  mem_stage_rv32_if.master bus,
  output logic             oWB,
  output logic [4:0]       oDregADDR,
  output logic [31:0]      oDregDATA,
  output logic [1:0]       oERR
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_load;
  logic [4:0]    r_rd;
  logic [4:0]    r_size;
  logic [1:0]    r_addr_lo;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_req_err;
  logic [31:0]   w_ldata;

  lsu_align_rv32 u_align (
    .i_size       (iDecodedOP),
    .i_addr_lo    (iMEMADDR[1:0]),
    .i_store      (~iRW),
    .i_wdata      (iMEMDATA),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_err        (w_req_err),
    .i_ld_size    (r_size),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (bus.iBUS_RDATA),
    .o_ldata      (w_ldata)
  );

  assign oSTALL = (r_state == ST_BUSY);

  // Transaction FSM with registered bus, writeback and error outputs
  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_load         <= 1'b0;
      r_rd           <= '0;
      r_size         <= '0;
      r_addr_lo      <= '0;
      bus.oBUS_REQ   <= 1'b0;
      bus.oBUS_WE    <= 1'b0;
      bus.oBUS_ADDR  <= '0;
      bus.oBUS_BE    <= '0;
      bus.oBUS_WDATA <= '0;
      oWB            <= 1'b0;
      oDregADDR      <= '0;
      oDregDATA      <= '0;
      oERR           <= ERR_NONE;
    end else begin
      oWB  <= 1'b0;
      oERR <= ERR_NONE;
      case (r_state)
        ST_IDLE: begin
          if (!iMEM) begin
            oWB       <= (iDregADDR != 5'd0);
            oDregADDR <= iDregADDR;
            oDregDATA <= iDregDATA;
          end else if (w_req_err) begin
            oERR <= ERR_ALIGN;
          end else begin
            r_state        <= ST_BUSY;
            r_cnt          <= '0;
            r_load         <= iRW;
            r_rd           <= iDregADDR;
            r_size         <= iDecodedOP;
            r_addr_lo      <= iMEMADDR[1:0];
            bus.oBUS_REQ   <= 1'b1;
            bus.oBUS_WE    <= ~iRW;
            bus.oBUS_ADDR  <= {iMEMADDR[31:2], 2'b00};
            bus.oBUS_BE    <= w_be;
            bus.oBUS_WDATA <= w_wdata;
          end
        end
        ST_BUSY: begin
          // An ack in the final allowed cycle still completes normally
          if (bus.iBUS_ACK) begin
            r_state      <= ST_IDLE;
            bus.oBUS_REQ <= 1'b0;
            if (r_load) begin
              oWB       <= (r_rd != 5'd0);
              oDregADDR <= r_rd;
              oDregDATA <= w_ldata;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= ST_IDLE;
            bus.oBUS_REQ <= 1'b0;
            oERR         <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
